// File: rtl/c1541_pkg.sv
// rtl/c1541_pkg.sv - shared types, limits and stepper decode for the c1541 head controller
package c1541_pkg;

    localparam int MAX_HT = 80;
    localparam int MIN_HT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAVE_REQ,
        ST_SAVE_WAIT,
        ST_LOAD_REQ,
        ST_LOAD_WAIT
    } head_state_e;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_OUT  = 2'd1,
        STEP_IN   = 2'd2
    } step_dir_e;

    // Phases advance 0,2,1,3 going outward; a jump by two phases is ambiguous and ignored.
    function automatic step_dir_e step_dir(input logic [1:0] prev, input logic [1:0] curr);
        step_dir_e dir;
        case ({prev, curr})
            4'b00_10, 4'b10_01, 4'b01_11, 4'b11_00: dir = STEP_OUT;
            4'b00_11, 4'b10_00, 4'b01_10, 4'b11_01: dir = STEP_IN;
            default:                                dir = STEP_NONE;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/c1541_head_ctrl_if.sv
// rtl/c1541_head_ctrl_if.sv - drive-logic / track-loader signals of the head controller
interface c1541_head_ctrl_if;
    logic [1:0] stp;
    logic       mtr;
    logic       buff_we;
    logic       disk_change;
    logic       busy;
    logic [6:0] half_track;
    logic [5:0] track;
    logic [5:0] req_track;
    logic       save_req;
    logic       load_req;
    logic       tr00_sense_n;
    logic       ready;

    modport master (
        output stp, mtr, buff_we, disk_change, busy,
        input  half_track, track, req_track, save_req, load_req, tr00_sense_n, ready
    );

    modport slave (
        input  stp, mtr, buff_we, disk_change, busy,
        output half_track, track, req_track, save_req, load_req, tr00_sense_n, ready
    );
endinterface

// File: rtl/c1541_step_decode.sv
// rtl/c1541_step_decode.sv - stepper phase history to one-cycle inc/dec pulses
module c1541_step_decode
    import c1541_pkg::*;
(
    input  logic       clk_c1541,
    input  logic [1:0] stp_i,
    input  logic       mtr_i,
    output logic       step_inc_o,
    output logic       step_dec_o
);

    logic [1:0] stp_q;
    step_dir_e  dir;

    // Tracks the phase even in reset so a static phase never looks like a step afterwards.
    always_ff @(posedge clk_c1541) begin
        stp_q <= stp_i;
    end

    assign dir        = step_dir(stp_q, stp_i);
    assign step_inc_o = mtr_i && (dir == STEP_OUT);
    assign step_dec_o = mtr_i && (dir == STEP_IN);

endmodule

// File: rtl/c1541_head_ctrl.sv
// rtl/c1541_head_ctrl.sv - head position tracking and track buffer save/load sequencing
module c1541_head_ctrl
    import c1541_pkg::*;
#(
    parameter int SETTLE_CYC = 320000,
    parameter int ACK_TMO    = 16,
    parameter int INIT_HT    = 36
) (
    input  logic                clk_c1541,
    input  logic                reset,
    c1541_head_ctrl_if.slave    hif
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam int TMO_W = $clog2(ACK_TMO + 1);

    head_state_e        state_q, state_d;
    logic [6:0]         half_track_q, half_track_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dirty_q, dirty_d;
    logic               loaded_valid_q, loaded_valid_d;
    logic [5:0]         loaded_track_q, loaded_track_d;
    logic [5:0]         req_track_q, req_track_d;
    logic               seen_busy_q, seen_busy_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               mtr_q;
    logic               ready_q;

    logic               step_inc, step_dec, stepped, mtr_fall, done;
    logic [5:0]         track_w;

    c1541_step_decode u_step (
        .clk_c1541  (clk_c1541),
        .stp_i      (hif.stp),
        .mtr_i      (hif.mtr),
        .step_inc_o (step_inc),
        .step_dec_o (step_dec)
    );

    assign track_w  = half_track_q[6:1];
    assign stepped  = step_inc | step_dec;
    assign mtr_fall = mtr_q & ~hif.mtr;

    always_comb begin
        state_d        = state_q;
        half_track_d   = half_track_q;
        cnt_d          = cnt_q;
        dirty_d        = dirty_q;
        loaded_valid_d = loaded_valid_q;
        loaded_track_d = loaded_track_q;
        req_track_d    = req_track_q;
        seen_busy_d    = seen_busy_q;
        tmo_d          = tmo_q;
        done           = 1'b0;

        if (step_inc && half_track_q < 7'(MAX_HT)) begin
            half_track_d = half_track_q + 7'd1;
        end else if (step_dec && half_track_q > 7'(MIN_HT)) begin
            half_track_d = half_track_q - 7'd1;
        end

        if (hif.buff_we && loaded_valid_q) begin
            dirty_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (mtr_fall && dirty_q) begin
                    state_d = ST_SAVE_REQ;
                end else if (stepped) begin
                    state_d = ST_SETTLE;
                end else if (hif.mtr && (!loaded_valid_q || loaded_track_q != track_w)) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(SETTLE_CYC);
                end
            end
            ST_SETTLE: begin
                if (mtr_fall && dirty_q) begin
                    state_d = ST_SAVE_REQ;
                end else if (!stepped) begin
                    if (cnt_q == '0) begin
                        state_d = dirty_q ? ST_SAVE_REQ : ST_LOAD_REQ;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_SAVE_REQ: begin
                dirty_d     = 1'b0;
                seen_busy_d = 1'b0;
                tmo_d       = '0;
                state_d     = ST_SAVE_WAIT;
            end
            ST_LOAD_REQ: begin
                seen_busy_d = 1'b0;
                tmo_d       = '0;
                state_d     = ST_LOAD_WAIT;
            end
            ST_SAVE_WAIT, ST_LOAD_WAIT: begin
                // A loader that never raises busy is assumed to have finished instantly.
                if (hif.busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q || tmo_q == TMO_W'(ACK_TMO - 1)) begin
                    done = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
                if (done) begin
                    if (state_q == ST_SAVE_WAIT) begin
                        state_d = (hif.mtr && track_w != loaded_track_q) ? ST_LOAD_REQ : ST_IDLE;
                    end else begin
                        loaded_track_d = req_track_q;
                        loaded_valid_d = 1'b1;
                        state_d        = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (stepped) begin
            cnt_d = CNT_W'(SETTLE_CYC);
        end

        if (hif.disk_change) begin
            dirty_d        = 1'b0;
            loaded_valid_d = 1'b0;
        end

        // req_track is captured on entry so it is valid alongside the request pulse.
        if (state_d == ST_SAVE_REQ) begin
            req_track_d = loaded_track_q;
        end else if (state_d == ST_LOAD_REQ) begin
            req_track_d = half_track_d[6:1];
        end
    end

    always_ff @(posedge clk_c1541) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            half_track_q   <= 7'(INIT_HT);
            cnt_q          <= '0;
            dirty_q        <= 1'b0;
            loaded_valid_q <= 1'b0;
            loaded_track_q <= '0;
            req_track_q    <= '0;
            seen_busy_q    <= 1'b0;
            tmo_q          <= '0;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            half_track_q   <= half_track_d;
            cnt_q          <= cnt_d;
            dirty_q        <= dirty_d;
            loaded_valid_q <= loaded_valid_d;
            loaded_track_q <= loaded_track_d;
            req_track_q    <= req_track_d;
            seen_busy_q    <= seen_busy_d;
            tmo_q          <= tmo_d;
            ready_q        <= (state_q == ST_IDLE) && loaded_valid_q &&
                              (loaded_track_q == track_w) && !hif.disk_change;
        end
        mtr_q <= hif.mtr;
    end

    assign hif.half_track   = half_track_q;
    assign hif.track        = track_w;
    assign hif.req_track    = req_track_q;
    assign hif.save_req     = (state_q == ST_SAVE_REQ);
    assign hif.load_req     = (state_q == ST_LOAD_REQ);
    assign hif.tr00_sense_n = (track_w != 6'd0);
    assign hif.ready        = ready_q;

endmodule

// File: tb/tb_c1541_head_ctrl.sv
// tb/tb_c1541_head_ctrl.sv - self-checking bench for c1541_head_ctrl
module tb_c1541_head_ctrl;

    localparam int S   = 40;
    localparam int T   = 6;
    localparam int IHT = 36;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       m;
        int         delta;
    } vec_t;

    logic clk_c1541 = 1'b0;
    logic reset;
    always #5 clk_c1541 = ~clk_c1541;

    c1541_head_ctrl_if dif ();

    c1541_head_ctrl #(.SETTLE_CYC(S), .ACK_TMO(T), .INIT_HT(IHT)) dut (
        .clk_c1541 (clk_c1541),
        .reset     (reset),
        .hif       (dif)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_save  = 0;
    int n_load  = 0;
    int n_both  = 0;
    int pos     = 0;
    bit resp_en = 1'b1;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_c1541);
    endtask

    // Position of a phase value along the outward sequence 0,2,1,3 (the map is its own inverse).
    function automatic int gray_pos(input int v);
        case (v)
            0: return 0;
            1: return 2;
            2: return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int model_step(input int ht, input int prev, input int cur, input bit m);
        int d;
        if (!m) return ht;
        d = (gray_pos(cur) - gray_pos(prev) + 4) % 4;
        if (d == 1) return (ht < 80) ? ht + 1 : ht;
        if (d == 3) return (ht > 2) ? ht - 1 : ht;
        return ht;
    endfunction

    task automatic step(input int dir);
        pos = (pos + dir + 4) % 4;
        dif.stp = 2'(gray_pos(pos));
        tick(1);
    endtask

    task automatic wait_req(input bit is_save, input int bound, output int cyc, output int rt);
        cyc = -1;
        rt  = -1;
        for (int i = 1; i <= bound; i++) begin
            tick(1);
            if (is_save ? dif.save_req : dif.load_req) begin
                cyc = i;
                rt  = int'(dif.req_track);
                break;
            end
        end
    endtask

    task automatic wait_ready(input int bound, output int cyc);
        cyc = -1;
        for (int i = 1; i <= bound; i++) begin
            tick(1);
            if (dif.ready) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dif.stp = 2'd0;
        dif.mtr = 1'b0;
        dif.buff_we = 1'b0;
        dif.disk_change = 1'b0;
        pos = 0;
        tick(3);
        reset = 1'b0;
        tick(1);
    endtask

    always begin
        @(posedge clk_c1541);
        #3;
        if (dif.save_req) n_save++;
        if (dif.load_req) n_load++;
        if (dif.save_req && dif.load_req) n_both++;
    end

    // Track loader: busy rises 3 cycles after a request and stays high for 10.
    initial begin
        dif.busy = 1'b0;
        forever begin
            @(negedge clk_c1541);
            if (resp_en && (dif.save_req || dif.load_req)) begin
                repeat (3) @(negedge clk_c1541);
                dif.busy = 1'b1;
                repeat (10) @(negedge clk_c1541);
                dif.busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt [18];
        int cyc, rt, n0, bad, mh, prev, s, e;
        bit m;

        vt[0]  = '{2'd0, 2'd2, 1'b1,  1};
        vt[1]  = '{2'd2, 2'd1, 1'b1,  1};
        vt[2]  = '{2'd1, 2'd3, 1'b1,  1};
        vt[3]  = '{2'd3, 2'd0, 1'b1,  1};
        vt[4]  = '{2'd0, 2'd3, 1'b1, -1};
        vt[5]  = '{2'd2, 2'd0, 1'b1, -1};
        vt[6]  = '{2'd1, 2'd2, 1'b1, -1};
        vt[7]  = '{2'd3, 2'd1, 1'b1, -1};
        vt[8]  = '{2'd0, 2'd1, 1'b1,  0};
        vt[9]  = '{2'd1, 2'd0, 1'b1,  0};
        vt[10] = '{2'd2, 2'd3, 1'b1,  0};
        vt[11] = '{2'd3, 2'd2, 1'b1,  0};
        vt[12] = '{2'd0, 2'd0, 1'b1,  0};
        vt[13] = '{2'd1, 2'd1, 1'b1,  0};
        vt[14] = '{2'd0, 2'd2, 1'b0,  0};
        vt[15] = '{2'd2, 2'd0, 1'b0,  0};
        vt[16] = '{2'd1, 2'd3, 1'b0,  0};
        vt[17] = '{2'd3, 2'd1, 1'b0,  0};

        do_reset();
        check("rst_half_track", int'(dif.half_track), 36);
        check("rst_track", int'(dif.track), 18);
        check("rst_req_track", int'(dif.req_track), 0);
        check("rst_save_req", int'(dif.save_req), 0);
        check("rst_load_req", int'(dif.load_req), 0);
        check("rst_ready", int'(dif.ready), 0);
        check("rst_tr00_sense_n", int'(dif.tr00_sense_n), 1);

        // Initial load after power-up settle.
        dif.mtr = 1'b1;
        wait_req(1'b0, S + 10, cyc, rt);
        check("init_load_seen", int'(cyc > 0), 1);
        check("init_load_track", rt, 18);
        wait_ready(40, cyc);
        check("init_ready", int'(cyc > 0), 1);
        check("init_load_count", n_load, 1);

        // Dirty track, three outward half-steps, save then load.
        dif.buff_we = 1'b1; tick(1); dif.buff_we = 1'b0;
        step(1);
        check("step1_half_track", int'(dif.half_track), 37);
        check("step1_track", int'(dif.track), 18);
        step(1); step(1);
        check("step3_half_track", int'(dif.half_track), 39);
        check("step3_track", int'(dif.track), 19);
        wait_req(1'b1, S + 10, cyc, rt);
        check("dirty_save_seen", int'(cyc > 0), 1);
        check("dirty_save_track", rt, 18);
        wait_req(1'b0, 40, cyc, rt);
        check("after_save_load_seen", int'(cyc > 0), 1);
        check("after_save_load_track", rt, 19);
        wait_ready(40, cyc);
        check("after_save_ready", int'(cyc > 0), 1);

        // Steps every S/2 cycles keep the head settling.
        n0 = n_save + n_load;
        for (int k = 0; k < 4; k++) begin
            step((k % 2 == 0) ? 1 : -1);
            if (k < 3) tick(S / 2 - 1);
        end
        check("no_req_while_stepping", n_save + n_load, n0);
        wait_req(1'b0, S + 10, cyc, rt);
        check("settle_latency_window", int'(cyc >= S && cyc <= S + 4), 1);
        wait_ready(40, cyc);
        check("resettle_ready", int'(cyc > 0), 1);

        // Clamping at both ends.
        for (int k = 0; k < 45; k++) step(1);
        check("clamp_max_half_track", int'(dif.half_track), 80);
        check("clamp_max_track", int'(dif.track), 40);
        for (int k = 0; k < 80; k++) step(-1);
        check("clamp_min_half_track", int'(dif.half_track), 2);
        check("clamp_min_track", int'(dif.track), 1);
        check("clamp_min_tr00_sense_n", int'(dif.tr00_sense_n), 1);
        wait_ready(3 * S + 60, cyc);
        check("clamp_min_ready", int'(cyc > 0), 1);

        // Motor off with a dirty buffer saves immediately, no load follows.
        dif.buff_we = 1'b1; tick(1); dif.buff_we = 1'b0;
        dif.mtr = 1'b0;
        wait_req(1'b1, 3, cyc, rt);
        check("mtr_off_save_cycle", cyc, 1);
        check("mtr_off_save_track", rt, 1);
        n0 = n_load;
        tick(2 * S + 40);
        check("mtr_off_no_load", n_load, n0);

        // Disk change during LOAD_WAIT invalidates the result and forces a reload.
        dif.mtr = 1'b1;
        tick(2);
        step(1); step(1);
        wait_req(1'b0, S + 10, cyc, rt);
        check("dc_load_seen", int'(cyc > 0), 1);
        check("dc_load_track", rt, 2);
        dif.disk_change = 1'b1;
        bad = 0;
        for (int k = 0; k < 25; k++) begin
            tick(1);
            if (dif.ready) bad++;
        end
        check("dc_ready_low", bad, 0);
        dif.disk_change = 1'b0;
        wait_req(1'b0, 2 * S + 20, cyc, rt);
        check("dc_reload_seen", int'(cyc > 0), 1);
        check("dc_reload_track", rt, 2);
        wait_ready(40, cyc);
        check("dc_reload_ready", int'(cyc > 0), 1);

        // Loader never raises busy: both transfers time out.
        resp_en = 1'b0;
        step(1); step(1);
        wait_req(1'b0, S + 10, cyc, rt);
        check("tmo_load_track", rt, 3);
        wait_ready(T + 10, cyc);
        check("tmo_load_window", int'(cyc >= T && cyc <= T + 4), 1);
        dif.buff_we = 1'b1; tick(1); dif.buff_we = 1'b0;
        step(1); step(1);
        wait_req(1'b1, S + 10, cyc, rt);
        check("tmo_save_track", rt, 3);
        wait_req(1'b0, T + 10, cyc, rt);
        check("tmo_save_window", int'(cyc >= T && cyc <= T + 4), 1);
        check("tmo_save_load_track", rt, 4);
        wait_ready(T + 10, cyc);
        check("tmo_ready", int'(cyc > 0), 1);
        resp_en = 1'b1;

        // Reset while settling towards a save abandons it.
        dif.buff_we = 1'b1; tick(1); dif.buff_we = 1'b0;
        step(1); step(1);
        tick(10);
        n0 = n_save;
        reset = 1'b1;
        dif.mtr = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2 * S);
        check("rst_mid_no_save", n_save, n0);
        check("rst_mid_half_track", int'(dif.half_track), 36);
        check("rst_mid_tr00_sense_n", int'(dif.tr00_sense_n), 1);

        // Transition table, then random phases against the model.
        do_reset();
        mh = IHT;
        prev = 0;
        for (int i = 0; i < 18; i++) begin
            dif.mtr = 1'b1;
            dif.stp = vt[i].a;
            tick(1);
            mh = model_step(mh, prev, int'(vt[i].a), 1'b1);
            dif.mtr = vt[i].m;
            dif.stp = vt[i].b;
            tick(1);
            e = mh + vt[i].delta;
            if (e > 80) e = 80;
            if (e < 2) e = 2;
            check($sformatf("table_%0d_half_track", i), int'(dif.half_track), e);
            mh = e;
            prev = int'(vt[i].b);
        end

        for (int i = 0; i < 300; i++) begin
            m = ($urandom % 4) != 0;
            s = int'($urandom % 4);
            dif.mtr = m;
            dif.stp = 2'(s);
            tick(1);
            mh = model_step(mh, prev, s, m);
            prev = s;
            check("rand_half_track", int'(dif.half_track), mh);
            check("rand_track", int'(dif.track), mh / 2);
        end

        check("never_both_req", n_both, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/c1541_head_ctrl.md
C1541_HEAD_CTRL -- requirements
Module: c1541_head_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 320000, head settle time in clk_c1541 cycles (10 ms at 32 MHz).
REQ-002 SHALL have parameter ACK_TMO, default 16, number of cycles to wait for busy to rise after a request.
REQ-003 SHALL have parameter INIT_HT, default 36, half-track number loaded at reset.
REQ-004 SHALL have ports, clock and reset first:
- clk_c1541  in  1  drive clock, 32 MHz; reset reset, synchronous, active-high; clock clk_c1541.
- reset  in  1  synchronous active-high reset.
- stp  in  2  stepper phase from the drive logic.
- mtr  in  1  spindle motor enable.
- buff_we  in  1  track buffer write strobe (marks the track dirty).
- disk_change  in  1  media change level.
- busy  in  1  track loader busy.
- half_track  out  7  head position, range 2..80.
- track  out  6  half_track[6:1], registered.
- req_track  out  6  track number for the current transfer.
- save_req  out  1  one-cycle save request.
- load_req  out  1  one-cycle load request.
- tr00_sense_n  out  1  low when track==0.
- ready  out  1  buffer valid for the current track.

Function
REQ-005 SHALL register stp each cycle and detect steps only while mtr=1. Outward (+1) transitions: 0->2, 2->1, 1->3, 3->0. Inward (-1) transitions: 0->3, 2->0, 1->2, 3->1. All other transitions SHALL be ignored.
REQ-006 SHALL clamp half_track: increment only if <80, decrement only if >2. The update SHALL take effect the cycle after the stp change, in any FSM state.
REQ-007 SHALL reload the settle counter with SETTLE_CYC on every accepted step.
REQ-008 SHALL keep dirty, loaded_valid and loaded_track[5:0] internally. buff_we SHALL set dirty only while loaded_valid=1.
REQ-009 FSM states: IDLE, SETTLE, SAVE_REQ, SAVE_WAIT, LOAD_REQ, LOAD_WAIT.
REQ-010 IDLE: on a step, go to SETTLE. Else if mtr=1 and (loaded_valid=0 or loaded_track!=track), go to SETTLE with counter=SETTLE_CYC.
REQ-011 SETTLE: decrement the counter. When it reaches 0: go to SAVE_REQ if dirty, else LOAD_REQ.
REQ-012 On a mtr 1->0 edge with dirty=1 in IDLE or SETTLE: go directly to SAVE_REQ, bypassing settle.
REQ-013 SAVE_REQ: assert save_req for one cycle, req_track=loaded_track, clear dirty, go to SAVE_WAIT.
REQ-014 LOAD_REQ: assert load_req for one cycle, req_track=track, go to LOAD_WAIT.
REQ-015 *_WAIT: wait for busy=1, then for busy=0. If busy stays 0 for ACK_TMO cycles after the request, the transfer SHALL be treated as complete.
REQ-016 On LOAD_WAIT completion: set loaded_track=req_track and loaded_valid=1.
REQ-017 On SAVE_WAIT completion: go to LOAD_REQ if mtr=1 and track!=loaded_track, else IDLE.
REQ-018 On LOAD_WAIT completion: go to IDLE. The IDLE re-check in REQ-010 SHALL handle any steps that occurred during the transfer.
REQ-019 disk_change=1 SHALL clear dirty and loaded_valid in any state. An in-flight wait SHALL still complete its handshake, but a load completing while disk_change=1 SHALL NOT set loaded_valid.
REQ-020 req_track SHALL hold its value from the request until the next request.
REQ-021 ready = (state==IDLE) & loaded_valid & (loaded_track==track) & ~disk_change, registered.
REQ-022 save_req and load_req SHALL never be asserted in the same cycle, and never within a *_WAIT state.

Reset
REQ-023 On reset: half_track=INIT_HT, track=18, req_track=0, save_req=0, load_req=0, ready=0, dirty=0, loaded_valid=0, loaded_track=0, settle counter=0, state=IDLE.
REQ-024 Reset asserted mid-transfer SHALL abandon the transfer with no save issued. tr00_sense_n SHALL be 1 after reset.

Structure
REQ-025 FSM state encoding, the step-direction decode function, and the constants MAX_HT=80 / MIN_HT=2 SHALL live in the shared package c1541_pkg.
REQ-026 One sub-module c1541_step_decode (stp history to inc/dec pulses) is natural; everything else stays flat.

Verification
REQ-027 Reset with mtr=1, busy responding after 3 cycles for 10 cycles -> after SETTLE_CYC: one load_req, req_track=18, then ready=1.
REQ-028 Loaded track 18, buff_we pulse, one outward step -> half_track 37, track 18. Two more steps -> track 19. After settle: save_req with req_track=18, then load_req with req_track=19.
REQ-029 Repeated steps every SETTLE_CYC/2 cycles -> no request until SETTLE_CYC after the last step.
REQ-030 At half_track=80, outward steps -> stays 80. At half_track=2, inward steps -> stays 2.
REQ-031 Dirty track 18, mtr 1->0 -> save_req the next cycle with req_track=18 and no load_req. disk_change during LOAD_WAIT -> ready stays 0 and a reload follows.
REQ-032 busy never asserted -> save/load completes after ACK_TMO cycles and the FSM returns to IDLE.
